// File: rtl/ps2_mouse_device_sm_if.sv
// ps2_mouse_device_sm_if
// Groups the handshakes around the emulated PS/2 mouse state machine:
//   rx_*   : command bytes from the device-side byte receiver (ready/ack)
//   tx_*   : bytes to the device-side byte transmitter (send/done)
//   move_* : 3-byte movement packets offered by the movement source
//   streaming, busy : status flags of the state machine
// The slave modport is the mouse state machine; the master modport is the
// surrounding environment (receiver, transmitter, movement source).
interface ps2_mouse_device_sm_if;
  logic [7:0] rx_byte;
  logic [1:0] rx_error;
  logic       rx_ready;
  logic       rx_ack;
  logic       tx_send;
  logic [7:0] tx_byte;
  logic       tx_done;
  logic       move_valid;
  logic [7:0] move_status;
  logic [7:0] move_dx;
  logic [7:0] move_dy;
  logic       move_accept;
  logic       streaming;
  logic       busy;

  modport slave (
    input  rx_byte, rx_error, rx_ready, tx_done,
    input  move_valid, move_status, move_dx, move_dy,
    output rx_ack, tx_send, tx_byte, move_accept, streaming, busy
  );

  modport master (
    output rx_byte, rx_error, rx_ready, tx_done,
    output move_valid, move_status, move_dx, move_dy,
    input  rx_ack, tx_send, tx_byte, move_accept, streaming, busy
  );
endinterface

// File: rtl/ps2_mouse_device_sm.sv
// ps2_mouse_device_sm
// Device-side PS/2 mouse emulation. Decodes host commands from the byte
// receiver, answers through the byte transmitter and, while reporting is
// enabled, streams 3-byte movement packets (status, DX, DY).
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : ps2_mouse_device_sm_if.slave (rx, tx, movement handshakes,
//           streaming and busy flags)
// Parameters:
//   BAT_DELAY : cycles between the FA acknowledge and the AA self-test byte
//   DEVICE_ID : ID byte sent after AA and in reply to F2
module ps2_mouse_device_sm #(
  parameter int unsigned BAT_DELAY = 1000,
  parameter logic [7:0]  DEVICE_ID = 8'h00
) (
  input logic clk,
  input logic reset,
  ps2_mouse_device_sm_if.slave bus
);

  // Last count value of the BAT wait; a zero delay behaves like a delay of one.
  localparam logic [23:0] BAT_LAST = (BAT_DELAY > 0) ? 24'(BAT_DELAY - 1) : 24'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_WAIT,
    ST_BAT_WAIT,
    ST_SEND_ID,
    ST_PKT0,
    ST_PKT1,
    ST_PKT2
  } state_t;

  state_t      state_q, state_d;
  state_t      next_q, next_d;
  logic        set_stream_q, set_stream_d;
  logic        streaming_q, streaming_d;
  logic [23:0] bat_cnt_q, bat_cnt_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_send_q, tx_send_d;
  logic        rx_ack_q, rx_ack_d;
  logic        move_accept_q, move_accept_d;
  logic [7:0]  pkt_status_q, pkt_status_d;
  logic [7:0]  pkt_dx_q, pkt_dx_d;
  logic [7:0]  pkt_dy_q, pkt_dy_d;

  logic        send_en;
  logic [7:0]  send_byte;
  state_t      send_next;
  logic        send_resend;

  // State register; reset aborts any reply or packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      next_q        <= ST_IDLE;
      set_stream_q  <= 1'b0;
      streaming_q   <= 1'b0;
      bat_cnt_q     <= '0;
      last_q        <= 8'h00;
      tx_byte_q     <= 8'h00;
      tx_send_q     <= 1'b0;
      rx_ack_q      <= 1'b0;
      move_accept_q <= 1'b0;
      pkt_status_q  <= 8'h00;
      pkt_dx_q      <= 8'h00;
      pkt_dy_q      <= 8'h00;
    end else begin
      state_q       <= state_d;
      next_q        <= next_d;
      set_stream_q  <= set_stream_d;
      streaming_q   <= streaming_d;
      bat_cnt_q     <= bat_cnt_d;
      last_q        <= last_d;
      tx_byte_q     <= tx_byte_d;
      tx_send_q     <= tx_send_d;
      rx_ack_q      <= rx_ack_d;
      move_accept_q <= move_accept_d;
      pkt_status_q  <= pkt_status_d;
      pkt_dx_q      <= pkt_dx_d;
      pkt_dy_q      <= pkt_dy_d;
    end
  end

  // Next-state logic. Every state that transmits fills in send_*; the shared
  // tail then pulses TX_SEND and parks in ST_TX_WAIT with next_q holding the
  // state to resume once the transmitter reports TX_DONE.
  always_comb begin
    state_d       = state_q;
    next_d        = next_q;
    set_stream_d  = set_stream_q;
    streaming_d   = streaming_q;
    bat_cnt_d     = bat_cnt_q;
    last_d        = last_q;
    tx_byte_d     = tx_byte_q;
    tx_send_d     = 1'b0;
    rx_ack_d      = 1'b0;
    move_accept_d = 1'b0;
    pkt_status_d  = pkt_status_q;
    pkt_dx_d      = pkt_dx_q;
    pkt_dy_d      = pkt_dy_q;
    send_en       = 1'b0;
    send_byte     = 8'h00;
    send_next     = ST_IDLE;
    send_resend   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Host commands win over a movement packet offered in the same cycle.
        if (bus.rx_ready) begin
          rx_ack_d     = 1'b1;
          send_en      = 1'b1;
          set_stream_d = 1'b0;
          if (bus.rx_error != 2'b00) begin
            send_byte = 8'hFE;
          end else begin
            case (bus.rx_byte)
              8'hFF: begin
                send_byte   = 8'hFA;
                streaming_d = 1'b0;
                bat_cnt_d   = '0;
                send_next   = ST_BAT_WAIT;
              end
              8'hF4: begin
                // Reporting turns on only once the FA has gone out.
                send_byte    = 8'hFA;
                set_stream_d = 1'b1;
              end
              8'hF5: begin
                send_byte   = 8'hFA;
                streaming_d = 1'b0;
              end
              8'hF2: begin
                send_byte = 8'hFA;
                send_next = ST_SEND_ID;
              end
              8'hFE: begin
                // A resend repeats the previous byte and must not overwrite it.
                send_byte   = last_q;
                send_resend = 1'b1;
              end
              default: send_byte = 8'hFE;
            endcase
          end
        end else if (streaming_q && bus.move_valid) begin
          pkt_status_d  = bus.move_status;
          pkt_dx_d      = bus.move_dx;
          pkt_dy_d      = bus.move_dy;
          move_accept_d = 1'b1;
          state_d       = ST_PKT0;
        end
      end
      ST_PKT0: begin
        // Bit 3 of the status byte is always set in a PS/2 movement packet.
        send_en   = 1'b1;
        send_byte = pkt_status_q | 8'h08;
        send_next = ST_PKT1;
      end
      ST_PKT1: begin
        send_en   = 1'b1;
        send_byte = pkt_dx_q;
        send_next = ST_PKT2;
      end
      ST_PKT2: begin
        send_en   = 1'b1;
        send_byte = pkt_dy_q;
        send_next = ST_IDLE;
      end
      ST_SEND_ID: begin
        send_en   = 1'b1;
        send_byte = DEVICE_ID;
        send_next = ST_IDLE;
      end
      ST_BAT_WAIT: begin
        if (bat_cnt_q >= BAT_LAST) begin
          send_en   = 1'b1;
          send_byte = 8'hAA;
          send_next = ST_SEND_ID;
        end else begin
          bat_cnt_d = bat_cnt_q + 24'd1;
        end
      end
      ST_TX_WAIT: begin
        if (bus.tx_done) begin
          state_d = next_q;
          if (set_stream_q) begin
            streaming_d  = 1'b1;
            set_stream_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (send_en) begin
      tx_send_d = 1'b1;
      tx_byte_d = send_byte;
      state_d   = ST_TX_WAIT;
      next_d    = send_next;
      if (!send_resend) begin
        last_d = send_byte;
      end
    end
  end

  assign bus.rx_ack      = rx_ack_q;
  assign bus.tx_send     = tx_send_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.move_accept = move_accept_q;
  assign bus.streaming   = streaming_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
